// File: rtl/display_mux_scheduler.sv
// rtl/display_mux_scheduler.sv - dual seven-segment digit scan scheduler with anti-ghosting blanking
//
// Purpose:
//   Alternates the 2:1 hex-digit mux and the two active-low digit enables
//   between digit 1 and digit 2. A blanking interval with both digits dark
//   separates every show interval, and the mux select only moves on entry to
//   a blanking state, so the mux has settled before the next digit lights.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous active-low reset
//   en          scan enable; low forces and holds blanking (BLANK2)
//   sel         mux select: 1 routes s1 to the decoder, 0 routes s2
//   an_n[1:0]   active-low digit enables: [0] digit 1, [1] digit 2
//   frame_tick  one-cycle pulse on the first cycle of each digit-1 show interval

module display_mux_scheduler #(
    parameter int SHOW_CYCLES  = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic       sel,
    output logic [1:0] an_n,
    output logic       frame_tick
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        SHOW1  = 2'd0,
        BLANK1 = 2'd1,
        SHOW2  = 2'd2,
        BLANK2 = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sel;
    logic [1:0]      r_an_n;
    logic            r_frame_tick;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_last;
    logic            w_sel_nxt;
    logic [1:0]      w_an_n_nxt;
    logic            w_frame_tick_nxt;

    // Terminal count for the dwell in the current state.
    always_comb begin
        w_last = BLANK_LAST;
        if (r_state == SHOW1 || r_state == SHOW2) begin
            w_last = SHOW_LAST;
        end
    end

    // Next state and dwell counter. Disabling the scan parks the FSM in BLANK2
    // so that resuming always begins with a full blank before digit 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        if (!en) begin
            w_state_nxt = BLANK2;
            w_cnt_nxt   = '0;
        end else if (r_cnt == w_last) begin
            w_cnt_nxt = '0;
            case (r_state)
                SHOW1:   w_state_nxt = BLANK1;
                BLANK1:  w_state_nxt = SHOW2;
                SHOW2:   w_state_nxt = BLANK2;
                default: w_state_nxt = SHOW1;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they are
    // Moore outputs of the state held in r_state with no path from en.
    // BLANK1 already selects s2 and BLANK2 already selects s1: the select is
    // switched while both digits are dark.
    always_comb begin
        w_sel_nxt  = 1'b1;
        w_an_n_nxt = 2'b11;
        case (w_state_nxt)
            SHOW1: begin
                w_sel_nxt  = 1'b1;
                w_an_n_nxt = 2'b10;
            end
            BLANK1: begin
                w_sel_nxt  = 1'b0;
                w_an_n_nxt = 2'b11;
            end
            SHOW2: begin
                w_sel_nxt  = 1'b0;
                w_an_n_nxt = 2'b01;
            end
            default: begin
                w_sel_nxt  = 1'b1;
                w_an_n_nxt = 2'b11;
            end
        endcase
        // SHOW1 is never followed directly by SHOW1, so entry is detected by
        // the current state differing from SHOW1.
        w_frame_tick_nxt = (w_state_nxt == SHOW1) && (r_state != SHOW1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= BLANK2;
            r_cnt        <= '0;
            r_sel        <= 1'b1;
            r_an_n       <= 2'b11;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sel        <= w_sel_nxt;
            r_an_n       <= w_an_n_nxt;
            r_frame_tick <= w_frame_tick_nxt;
        end
    end

    assign sel        = r_sel;
    assign an_n       = r_an_n;
    assign frame_tick = r_frame_tick;

endmodule
